// File: rtl/mmio_timer_core_pkg.sv
// rtl/mmio_timer_core_pkg.sv - register map, control bit indices and slot FSM states
// Shared constants for the timer slot device. slot_fsm_t is meant to be
// reused by other slot devices that sit behind the MMIO controller.
package mmio_timer_core_pkg;

  // Register word indices (reg_addr)
  localparam logic [7:0] TIMER_REG_CTRL     = 8'h00;
  localparam logic [7:0] TIMER_REG_STATUS   = 8'h01;
  localparam logic [7:0] TIMER_REG_COUNT_LO = 8'h02;
  localparam logic [7:0] TIMER_REG_COUNT_HI = 8'h03;
  localparam logic [7:0] TIMER_REG_CMP_LO   = 8'h04;
  localparam logic [7:0] TIMER_REG_CMP_HI   = 8'h05;
  localparam logic [7:0] TIMER_REG_PRESCALE = 8'h06;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_CLEAR_BIT       = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;
  localparam int CTRL_AUTO_RELOAD_BIT = 3;

  // STATUS bit positions
  localparam int STATUS_MATCH_BIT = 0;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_DONE = 1'b1
  } slot_fsm_t;

endpackage

// File: rtl/mmio_timer_core_tick_gen.sv
// rtl/mmio_timer_core_tick_gen.sv - prescaler producing a one-cycle count tick
// Ports:
//   aclk, arst_n  clock, asynchronous active-low reset
//   enable        run the divider; 0 freezes it
//   clear         zero the divider this cycle; suppresses the tick
//   prescale      divide value; tick every prescale+1 enabled cycles
//   tick          one-cycle pulse, combinational from the divider state
module timer_tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] DIV_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] div_cnt;
  logic                  at_terminal;

  // >= rather than == so that lowering PRESCALE below the in-flight count
  // still ticks on the next enabled cycle instead of running the divider
  // all the way round.
  assign at_terminal = (div_cnt >= prescale);
  assign tick        = enable && !clear && at_terminal;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (at_terminal) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_ONE;
    end
  end

endmodule

// File: rtl/mmio_timer_core.sv
// rtl/mmio_timer_core.sv - MMIO slot 0 timer: 64-bit counter, compare match, irq
// Ports:
//   aclk, arst_n            clock, asynchronous active-low reset
//   chip_select, read,      slot command from the MMIO controller
//   write, reg_addr,
//   wr_data
//   rd_data                 read data, held until the next accepted access
//   wr_done, rd_done        access complete, held until transaction_completed
//   idle                    access FSM in SLOT_IDLE
//   signal_received         one-cycle pulse after a command is accepted
//   slave_error             write hit a read-only register (held)
//   decode_error            access hit an unmapped index (held)
//   transaction_completed   controller finished its AXI response
//   irq                     level interrupt: match_flag AND irq_en
module mmio_timer_core
  import mmio_timer_core_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int COUNT_W    = 64
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic        chip_select,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        wr_done,
  output logic        rd_done,
  output logic        idle,
  output logic        signal_received,
  output logic        slave_error,
  output logic        decode_error,
  input  logic        transaction_completed,
  output logic        irq
);

  localparam int HI_W = COUNT_W - 32;

  slot_fsm_t state, state_nxt;
  logic      op_write;

  logic                  ctrl_enable, ctrl_irq_en, ctrl_auto_reload;
  logic                  match_flag;
  logic [COUNT_W-1:0]    count, cmp;
  logic [HI_W-1:0]       count_hi_shadow;
  logic [PRESCALE_W-1:0] prescale;

  logic            trigger, wr_fire, rd_fire;
  logic            addr_mapped, addr_ro;
  logic            clear_pulse, status_w1c, tick, hit;
  logic [COUNT_W:0] count_inc;
  logic [31:0]     rd_mux;

  // Commands are only looked at in SLOT_IDLE, so a chip_select left high
  // during SLOT_DONE cannot re-execute the access.
  assign trigger     = (state == SLOT_IDLE) && chip_select && (write || read);
  assign wr_fire     = trigger && write;
  assign rd_fire     = trigger && !write;
  assign addr_mapped = (reg_addr <= TIMER_REG_PRESCALE);
  assign addr_ro     = (reg_addr == TIMER_REG_COUNT_LO) || (reg_addr == TIMER_REG_COUNT_HI);
  assign clear_pulse = wr_fire && (reg_addr == TIMER_REG_CTRL) && wr_data[CTRL_CLEAR_BIT];
  assign status_w1c  = wr_fire && (reg_addr == TIMER_REG_STATUS) && wr_data[STATUS_MATCH_BIT];

  // One extra bit so the all-ones -> 0 wrap can never equal cmp: wrapping
  // is silent even when cmp is 0.
  assign count_inc = {1'b0, count} + {{COUNT_W{1'b0}}, 1'b1};
  assign hit       = tick && (count_inc == {1'b0, cmp});
  assign irq       = match_flag && ctrl_irq_en;

  timer_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick_gen (
    .aclk     (aclk),
    .arst_n   (arst_n),
    .enable   (ctrl_enable),
    .clear    (clear_pulse),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      TIMER_REG_CTRL:     rd_mux = {28'd0, ctrl_auto_reload, ctrl_irq_en, 1'b0, ctrl_enable};
      TIMER_REG_STATUS:   rd_mux = {31'd0, match_flag};
      TIMER_REG_COUNT_LO: rd_mux = count[31:0];
      TIMER_REG_COUNT_HI: rd_mux = 32'(count_hi_shadow);
      TIMER_REG_CMP_LO:   rd_mux = cmp[31:0];
      TIMER_REG_CMP_HI:   rd_mux = 32'(cmp[COUNT_W-1:32]);
      TIMER_REG_PRESCALE: rd_mux = 32'(prescale);
      default:            rd_mux = '0;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state <= SLOT_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idle      = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      SLOT_IDLE: begin
        idle = 1'b1;
        if (trigger) state_nxt = SLOT_DONE;
      end
      SLOT_DONE: begin
        wr_done = op_write;
        rd_done = !op_write;
        if (transaction_completed) state_nxt = SLOT_IDLE;
      end
      default: state_nxt = SLOT_IDLE;
    endcase
  end

  // Access-side outputs: captured at accept and held through SLOT_DONE and
  // beyond, since the controller samples them after chip_select drops.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      op_write        <= 1'b0;
      signal_received <= 1'b0;
      slave_error     <= 1'b0;
      decode_error    <= 1'b0;
      rd_data         <= '0;
      count_hi_shadow <= '0;
    end else begin
      signal_received <= trigger;
      if (trigger) begin
        op_write     <= write;
        slave_error  <= write && addr_ro;
        decode_error <= !addr_mapped;
      end
      if (rd_fire) begin
        rd_data <= rd_mux;
        if (reg_addr == TIMER_REG_COUNT_LO) count_hi_shadow <= count[COUNT_W-1:32];
      end
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      ctrl_enable      <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      cmp              <= '0;
      prescale         <= '0;
    end else if (wr_fire) begin
      case (reg_addr)
        TIMER_REG_CTRL: begin
          ctrl_enable      <= wr_data[CTRL_ENABLE_BIT];
          ctrl_irq_en      <= wr_data[CTRL_IRQ_EN_BIT];
          ctrl_auto_reload <= wr_data[CTRL_AUTO_RELOAD_BIT];
        end
        TIMER_REG_CMP_LO:   cmp[31:0]         <= wr_data;
        TIMER_REG_CMP_HI:   cmp[COUNT_W-1:32] <= wr_data[HI_W-1:0];
        TIMER_REG_PRESCALE: prescale          <= wr_data[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clear_pulse) begin
      count <= '0;
    end else if (tick) begin
      count <= (hit && ctrl_auto_reload) ? '0 : count_inc[COUNT_W-1:0];
    end
  end

  // Hardware set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n)         match_flag <= 1'b0;
    else if (hit)        match_flag <= 1'b1;
    else if (status_w1c) match_flag <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_timer_core.sv
// tb/tb_mmio_timer_core.sv - directed self-checking bench for mmio_timer_core
module tb_mmio_timer_core;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic        chip_select = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] wr_data = '0;
  logic        transaction_completed = 1'b0;
  logic [31:0] rd_data;
  logic        wr_done, rd_done, idle, signal_received;
  logic        slave_error, decode_error, irq;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  typedef struct {
    logic        is_wr;
    logic [31:0] rd;
    logic        serr;
    logic        derr;
  } exp_t;

  exp_t sb_q[$];

  mmio_timer_core dut (
    .aclk                  (aclk),
    .arst_n                (arst_n),
    .chip_select           (chip_select),
    .read                  (read),
    .write                 (write),
    .reg_addr              (reg_addr),
    .wr_data               (wr_data),
    .rd_data               (rd_data),
    .wr_done               (wr_done),
    .rd_done               (rd_done),
    .idle                  (idle),
    .signal_received       (signal_received),
    .slave_error           (slave_error),
    .decode_error          (decode_error),
    .transaction_completed (transaction_completed),
    .irq                   (irq)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full slot access: command driven on a negedge, accepted at the next
  // posedge, response completed one cycle later.
  task automatic access(input logic is_wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_serr, input logic exp_derr);
    exp_t e;
    exp_t got;
    @(negedge aclk);
    chip_select = 1'b1;
    write       = is_wr;
    read        = !is_wr;
    reg_addr    = addr;
    wr_data     = data;
    e.is_wr = is_wr; e.rd = exp_rd; e.serr = exp_serr; e.derr = exp_derr;
    sb_q.push_back(e);
    @(posedge aclk); #1;
    got = sb_q.pop_front();
    chk("signal_received", signal_received, 1);
    chk(got.is_wr ? "wr_done" : "rd_done", got.is_wr ? wr_done : rd_done, 1);
    chk("idle_in_done", idle, 0);
    if (!got.is_wr) chk($sformatf("rd_data[%0h]", addr), rd_data, got.rd);
    chk("slave_error", slave_error, got.serr);
    chk("decode_error", decode_error, got.derr);
    @(negedge aclk);
    chip_select = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    transaction_completed = 1'b1;
    @(posedge aclk); #1;
    chk("idle_after", idle, 1);
    chk("signal_received_low", signal_received, 0);
    chk("slave_error_held", slave_error, got.serr);
    chk("decode_error_held", decode_error, got.derr);
    @(negedge aclk);
    transaction_completed = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    access(1'b1, addr, data, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] addr, input logic [31:0] exp);
    access(1'b0, addr, 32'd0, exp, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_sig", signal_received, 0);
    chk("rst_serr", slave_error, 0);
    chk("rst_derr", decode_error, 0);
    chk("rst_irq", irq, 0);
    @(negedge aclk);
    arst_n = 1'b1;

    for (int a = 0; a < 7; a++) rd_reg(8'(a), 32'd0);

    // CMP_HI read-back, PRESCALE upper bits read as 0
    wr_reg(8'h05, 32'h1234_5678);
    rd_reg(8'h05, 32'h1234_5678);
    wr_reg(8'h05, 32'd0);
    wr_reg(8'h06, 32'h00A5_0003);
    rd_reg(8'h06, 32'd3);

    // Divide by 4: enable at edge E, ticks at E+4k; read at E+40 sees 9,
    // disable at E+43 leaves 10.
    wr_reg(8'h00, 32'h1);
    repeat (37) @(negedge aclk);
    rd_reg(8'h02, 32'd9);
    wr_reg(8'h00, 32'h0);
    rd_reg(8'h02, 32'd10);
    rd_reg(8'h03, 32'd0);

    // Match with auto-reload, clear on the same write: match every 5 ticks
    wr_reg(8'h04, 32'd5);
    wr_reg(8'h06, 32'd0);
    wr_reg(8'h00, 32'hF);                 // edge E
    repeat (3) @(posedge aclk);
    #1 chk("irq_before_match", irq, 0);    // after E+4
    @(posedge aclk);
    #1 chk("irq_at_match", irq, 1);        // after E+5
    rd_reg(8'h02, 32'd0);                 // E+6: reloaded to 0
    rd_reg(8'h02, 32'd3);                 // E+9
    repeat (3) @(negedge aclk);
    wr_reg(8'h01, 32'h1);                 // E+15: W1C on a match cycle
    chk("w1c_vs_match_irq", irq, 1);
    rd_reg(8'h01, 32'h1);
    wr_reg(8'h00, 32'h4);                 // stop counting, keep irq_en
    wr_reg(8'h01, 32'h1);
    chk("w1c_irq_low", irq, 0);
    rd_reg(8'h01, 32'h0);
    rd_reg(8'h00, 32'h4);
    rd_reg(8'h02, 32'd1);

    // Error flags
    access(1'b1, 8'h02, 32'hABCD, 32'd0, 1'b1, 1'b0);
    repeat (4) @(negedge aclk);
    chk("serr_still_held", slave_error, 1);
    access(1'b0, 8'h20, 32'd0, 32'd0, 1'b0, 1'b1);
    access(1'b1, 8'h30, 32'hFFFF, 32'd0, 1'b0, 1'b1);
    rd_reg(8'h02, 32'd1);

    // Command held through DONE: CTRL enable+clear must execute once
    @(negedge aclk);
    chip_select = 1'b1;
    write    = 1'b1;
    reg_addr = 8'h00;
    wr_data  = 32'h3;
    @(posedge aclk);                      // edge A
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      chk("held_wr_done", wr_done, 1);
      if (signal_received) pulses++;
    end
    chip_select = 1'b0;
    write = 1'b0;
    transaction_completed = 1'b1;
    @(posedge aclk);
    #1 chk("held_idle_after", idle, 1);
    @(negedge aclk);
    transaction_completed = 1'b0;
    chk("held_sig_pulses", 64'(pulses), 1);
    wr_reg(8'h00, 32'h0);                 // A+8: 8 ticks since the clear
    rd_reg(8'h02, 32'd8);

    // Wrap: preload near all-ones, cmp=0, three ticks -> 1, no match
    wr_reg(8'h01, 32'h1);
    wr_reg(8'h04, 32'd0);
    wr_reg(8'h05, 32'd0);
    @(negedge aclk);
    force dut.count = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.count;
    rd_reg(8'h02, 32'hFFFF_FFFE);
    rd_reg(8'h03, 32'hFFFF_FFFF);
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h00, 32'h0);
    rd_reg(8'h02, 32'd1);
    rd_reg(8'h03, 32'd0);
    rd_reg(8'h01, 32'd0);

    // Reset during DONE
    @(negedge aclk);
    chip_select = 1'b1;
    read     = 1'b1;
    reg_addr = 8'h00;
    @(posedge aclk);
    #1 chk("pre_reset_rd_done", rd_done, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("reset_rd_done", rd_done, 0);
    chk("reset_idle", idle, 1);
    chk("reset_sig", signal_received, 0);
    @(negedge aclk);
    chip_select = 1'b0;
    read = 1'b0;
    arst_n = 1'b1;
    rd_reg(8'h02, 32'd0);
    rd_reg(8'h00, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
